shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Upstream control stage for the n-bit shift register.
- Accepts parallel words over a valid/ready handshake.
- Issues the load command, then one shift command per accepted serial bit, over the register's sel/din interface.
- Reads the register's parallel output back and presents a serial bit stream with valid/ready backpressure, producing one frame per word.

Parameters:
WIDTH, 4, word width; must match the shift register's WIDTH; legal range ≥ 2.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
s_data  input  WIDTH  parallel word to serialize.
s_msb_first  input  1  direction for this word; sampled with s_data (1 = MSB first, 0 = LSB first).
s_valid  input  1  s_data/s_msb_first valid.
s_ready  output  1  sequencer can accept a word.
sr_sel  output  2  command to shift register: 00 shift left, 01 shift right, 10 load, 11 hold.
sr_din  output  WIDTH  load data to shift register.
sr_q  input  WIDTH  shift register parallel output (dout).
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out valid.
ser_ready  input  1  sink accepts ser_out.
frame_done  output  1  one-cycle pulse after the last bit of a frame is accepted.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, bit counter=0, captured word/direction=0, frame_done=0.
  - sr_sel=11, sr_din=0, ser_valid=0, ser_out=0.
  - s_ready=0 while rst_n is low.
- States: IDLE, LOAD, SHIFT (PARITY when the option is enabled).
- sr_sel, sr_din, s_ready, ser_valid and ser_out are combinational decodes of registered state; frame_done is registered.
- IDLE:
  - s_ready=1, sr_sel=11, ser_valid=0.
  - On s_valid&&s_ready: capture s_data and s_msb_first, go to LOAD.
- LOAD (1 cycle):
  - s_ready=0, sr_sel=10, sr_din=captured word.
  - Register holds the word at the next edge. Go to SHIFT, counter=0.
- SHIFT:
  - ser_valid=1.
  - ser_out = sr_q[WIDTH-1] if MSB-first, else sr_q[0].
  - Bit accepted when ser_valid&&ser_ready: sr_sel = 00 (MSB-first) or 01 (LSB-first), counter += 1.
  - ser_ready low: sr_sel=11; ser_out and counter hold.
  - Accept with counter==WIDTH-1: go to IDLE and assert frame_done for the next cycle. The final shift command is issued and is harmless.
- Latency: handshake on edge E0 → LOAD during cycle 1 → first bit valid in cycle 2. A frame takes WIDTH+1 cycles with no backpressure.
- Back-to-back: frame_done cycle is IDLE, so a new word may be accepted in the same cycle. Minimum period is WIDTH+2 cycles per word.
- s_valid while busy: s_ready=0, so the upstream must hold its data; no capture occurs.
- Counter width: $clog2(WIDTH) bits, never exceeds WIDTH-1.
- Reset mid-frame: immediate return to IDLE, frame abandoned, no frame_done. Shift register contents are undefined from the sequencer's view; the next frame reloads.
- s_msb_first changes mid-frame: ignored; the captured value governs the whole frame.

Optional Feature:
- Macro: SHIFT_SEQ_PARITY_EN.
- Defined:
  - After the last data bit is accepted, go to PARITY instead of IDLE.
  - PARITY: ser_valid=1, ser_out = XOR of the captured word (even parity), sr_sel=11.
  - On accept, go to IDLE with frame_done. Frame becomes WIDTH+1 bits.
- Undefined: no PARITY state, no parity logic; frame is WIDTH bits.

Test Plan:
- Reset: rst_n low with s_valid=1 → s_ready=0, sr_sel=11, ser_valid=0, frame_done=0. Release → s_ready=1.
- MSB-first 4'b1011, ser_ready=1:
  - sr_sel sequence 10,00,00,00,00.
  - ser_out 1,0,1,1 in cycles 2-5.
  - frame_done pulse in cycle 6.
- LSB-first 4'b1011, ser_ready=1: sr_sel 10,01,01,01,01; ser_out 1,1,0,1; frame_done after the 4th bit.
- Backpressure:
  - MSB-first 4'b1100, ser_ready low for 2 cycles before bit 2 → sr_sel=11 and ser_out=1 held during the stall.
  - Stream is still 1,1,0,0; frame_done is delayed 2 cycles.
- Busy and back-to-back: second word presented during SHIFT → s_ready=0, not captured until frame_done cycle. Then LOAD follows immediately; both frames are correct.
- Reset mid-frame after 2 bits of 4'b0110 → IDLE next cycle, no frame_done. New word 4'b1001 serializes as 1,0,0,1.
- With SHIFT_SEQ_PARITY_EN: 4'b1011 MSB-first → 1,0,1,1,1 (parity bit 1) and frame_done after the 5th bit.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// Purpose: serializes parallel words through an external n-bit shift register,
//    issuing load/shift/hold commands over sr_sel/sr_din and returning
//    the register's end bit as a valid/ready serial stream.
// Latency: word accepted on edge E0, LOAD in cycle 1, first serial bit valid
//    in cycle 2; WIDTH+1 cycles per frame, WIDTH+2 per word back-to-back.
// Backpressure: s_ready only in IDLE (and never during reset); ser_ready low
//    holds the register (sr_sel=11), the current bit and the counter.
// Ports:
//    clk, rst_n              clock, async active-low reset
//    s_data/s_msb_first      word and bit order, s_valid/s_ready handshake
//    sr_sel/sr_din/sr_q      command, load data and readback of the register
//    ser_out/ser_valid/ser_ready  serial stream; frame_done pulses after last bit
// Option: define SHIFT_SEQ_PARITY_EN to append an even-parity bit per frame.

module shift_reg_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_msb_first,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [1:0]       sr_sel,
   output logic [WIDTH-1:0] sr_din,
   input  logic [WIDTH-1:0] sr_q,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] SEL_SHL  = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_LOAD = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

`ifdef SHIFT_SEQ_PARITY_EN
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] word;
   logic             msb_first;
   logic             bit_accept;
   logic             done_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         word       <= '0;
         msb_first  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done_nxt;
         if (s_valid && s_ready) begin
            word      <= s_data;
            msb_first <= s_msb_first;
         end
         if (state == LOAD) begin
            cnt <= '0;
         end else if (bit_accept) begin
            // Wrap on the last bit so the counter never reaches WIDTH.
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      sr_sel     = SEL_HOLD;
      sr_din     = '0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      bit_accept = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            // Gate with rst_n so the upstream sees not-ready while reset is held.
            s_ready = rst_n;
            if (s_valid && rst_n) state_nxt = LOAD;
         end
         LOAD: begin
            sr_sel    = SEL_LOAD;
            sr_din    = word;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = msb_first ? sr_q[WIDTH-1] : sr_q[0];
            if (ser_ready) begin
               bit_accept = 1'b1;
               // The command after the last bit is harmless: the next frame reloads.
               sr_sel = msb_first ? SEL_SHL : SEL_SHR;
               if (cnt == LAST) begin
`ifdef SHIFT_SEQ_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
`endif
               end
            end
         end
`ifdef SHIFT_SEQ_PARITY_EN
         PARITY: begin
            ser_valid = 1'b1;
            ser_out   = ^word;
            if (ser_ready) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Purpose: directed table-driven bench for shift_reg_sequencer with a
//    behavioural shift register closing the sr_sel/sr_din/sr_q loop.
// Latency: one table row per clock; inputs driven on the falling edge,
//    outputs sampled 1 time unit later.
// Backpressure: ser_ready and s_valid are driven per row from the tables.

module tb_shift_reg_sequencer;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] s_data;
   logic         s_msb_first;
   logic         s_valid;
   logic         s_ready;
   logic [1:0]   sr_sel;
   logic [W-1:0] sr_din;
   logic [W-1:0] sr_q;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_ready;
   logic         frame_done;

   int checks = 0;
   int errors = 0;

   shift_reg_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_msb_first(s_msb_first), .s_valid(s_valid), .s_ready(s_ready),
      .sr_sel(sr_sel), .sr_din(sr_din), .sr_q(sr_q),
      .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural n-bit shift register: 00 left, 01 right, 10 load, 11 hold.
   initial sr_q = '0;
   always @(posedge clk) begin
      case (sr_sel)
         2'b00:   sr_q <= {sr_q[W-2:0], 1'b0};
         2'b01:   sr_q <= {1'b0, sr_q[W-1:1]};
         2'b10:   sr_q <= sr_din;
         default: sr_q <= sr_q;
      endcase
   end

   typedef struct {
      logic         sv;
      logic [W-1:0] sd;
      logic         sm;
      logic         sr;
      logic         e_rdy;
      logic [1:0]   e_sel;
      logic [W-1:0] e_din;
      logic         e_vld;
      logic         e_out;
      logic         e_fd;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic sv, input logic [W-1:0] sd, input logic sm, input logic sr,
                      input logic e_rdy, input logic [1:0] e_sel, input logic [W-1:0] e_din,
                      input logic e_vld, input logic e_out, input logic e_fd);
      vec_t v;
      v.sv = sv; v.sd = sd; v.sm = sm; v.sr = sr;
      v.e_rdy = e_rdy; v.e_sel = e_sel; v.e_din = e_din;
      v.e_vld = e_vld; v.e_out = e_out; v.e_fd = e_fd;
      vq.push_back(v);
   endtask

   task automatic apply(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         s_valid     = vq[i].sv;
         s_data      = vq[i].sd;
         s_msb_first = vq[i].sm;
         ser_ready   = vq[i].sr;
         #1;
         chk($sformatf("%s[%0d] s_ready", tag, i), 32'(s_ready), 32'(vq[i].e_rdy));
         chk($sformatf("%s[%0d] sr_sel", tag, i), 32'(sr_sel), 32'(vq[i].e_sel));
         chk($sformatf("%s[%0d] sr_din", tag, i), 32'(sr_din), 32'(vq[i].e_din));
         chk($sformatf("%s[%0d] ser_valid", tag, i), 32'(ser_valid), 32'(vq[i].e_vld));
         chk($sformatf("%s[%0d] ser_out", tag, i), 32'(ser_out), 32'(vq[i].e_out));
         chk($sformatf("%s[%0d] frame_done", tag, i), 32'(frame_done), 32'(vq[i].e_fd));
      end
      vq.delete();
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b1; s_data = 4'b1111; s_msb_first = 1'b1; ser_ready = 1'b1;

      // Reset held with s_valid asserted.
      #12;
      chk("rst s_ready", 32'(s_ready), 32'd0);
      chk("rst sr_sel", 32'(sr_sel), 32'd3);
      chk("rst sr_din", 32'(sr_din), 32'd0);
      chk("rst ser_valid", 32'(ser_valid), 32'd0);
      chk("rst ser_out", 32'(ser_out), 32'd0);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; s_valid = 1'b0;
      #1;
      chk("rel s_ready", 32'(s_ready), 32'd1);

      // MSB-first 1011, no backpressure.
      add(1, 4'b1011, 1, 1, 1, 2'b11, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b10, 4'b1011, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
`ifdef SHIFT_SEQ_PARITY_EN
      add(0, 4'b0000, 0, 1, 0, 2'b11, 4'b0000, 1, 1, 0);
`endif
      add(0, 4'b0000, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 1);
      apply("msb1011");

      // LSB-first 1011.
      add(1, 4'b1011, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b10, 4'b1011, 0, 0, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 1, 0);
`ifdef SHIFT_SEQ_PARITY_EN
      add(0, 4'b0000, 1, 1, 0, 2'b11, 4'b0000, 1, 1, 0);
`endif
      add(0, 4'b0000, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 1);
      apply("lsb1011");

      // MSB-first 1100 with a 2-cycle stall before bit 2.
      add(1, 4'b1100, 1, 1, 1, 2'b11, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b10, 4'b1100, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 0, 0, 2'b11, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 0, 0, 2'b11, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
`ifdef SHIFT_SEQ_PARITY_EN
      add(0, 4'b0000, 0, 1, 0, 2'b11, 4'b0000, 1, 0, 0);
`endif
      add(0, 4'b0000, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 1);
      apply("stall1100");

      // Word B (0011 LSB-first) held during frame A (0101 MSB-first).
      add(1, 4'b0101, 1, 1, 1, 2'b11, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b10, 4'b0101, 0, 0, 0);
      add(1, 4'b0011, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(1, 4'b0011, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      add(1, 4'b0011, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(1, 4'b0011, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
`ifdef SHIFT_SEQ_PARITY_EN
      add(1, 4'b0011, 0, 1, 0, 2'b11, 4'b0000, 1, 0, 0);
`endif
      add(1, 4'b0011, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 1);
      add(0, 4'b0000, 1, 1, 0, 2'b10, 4'b0011, 0, 0, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 1, 1, 0, 2'b01, 4'b0000, 1, 0, 0);
`ifdef SHIFT_SEQ_PARITY_EN
      add(0, 4'b0000, 1, 1, 0, 2'b11, 4'b0000, 1, 0, 0);
`endif
      add(0, 4'b0000, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 1);
      apply("b2b");

      // Reset after two bits of 0110.
      add(1, 4'b0110, 1, 1, 1, 2'b11, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b10, 4'b0110, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      apply("pre_rst");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst s_ready", 32'(s_ready), 32'd0);
      chk("midrst sr_sel", 32'(sr_sel), 32'd3);
      chk("midrst ser_valid", 32'(ser_valid), 32'd0);
      chk("midrst frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst s_ready", 32'(s_ready), 32'd1);
      chk("postrst ser_valid", 32'(ser_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("postrst2 frame_done", 32'(frame_done), 32'd0);
      chk("postrst2 s_ready", 32'(s_ready), 32'd1);

      // Fresh frame 1001 MSB-first after the abandoned one.
      add(1, 4'b1001, 1, 1, 1, 2'b11, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b10, 4'b1001, 0, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 0, 0);
      add(0, 4'b0000, 0, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
`ifdef SHIFT_SEQ_PARITY_EN
      add(0, 4'b0000, 0, 1, 0, 2'b11, 4'b0000, 1, 0, 0);
`endif
      add(0, 4'b0000, 0, 1, 1, 2'b11, 4'b0000, 0, 0, 1);
      apply("msb1001");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
